fetch_ras: RTL
==============

FETCH_RAS -- requirements
Module: fetch_ras

Interface
REQ-001 SHALL have parameter RAS_DEPTH, default 16, number of stack entries; power of two, at least 4.
REQ-002 SHALL have parameter PTR_W, default 4, which is log2(RAS_DEPTH).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 ras_valid_f0_i  input  1  the f0 prediction carries a RAS operation; this is the BTB hit qualifier.
REQ-006 ras_ctl_f0_i  input  2  RAS control from the BTB: 00 none, 01 push, 10 pop, 11 pop-then-push.
REQ-007 ras_pushpc_f0_i  input  64  return address to push; upstream supplies branch PC + 4.
REQ-008 ras_recover_i  input  1  mispredict repair request from the retire/redirect logic.
REQ-009 ras_recover_tos_i  input  PTR_W  checkpointed top-of-stack pointer.
REQ-010 ras_recover_cnt_i  input  PTR_W+1  checkpointed occupancy.
REQ-011 ras_recover_data_i  input  64  checkpointed top-entry contents.
REQ-012 ras_recover_ctl_i  input  2  the mispredicted branch's own RAS control, re-applied after restore.
REQ-013 ras_recover_pc_i  input  64  push address for the re-applied control.
REQ-014 ras_target_f0_o  output  64  predicted return target, entry[tos], combinational from registers.
REQ-015 ras_empty_o  output  1  occupancy is 0.
REQ-016 ras_full_o  output  1  occupancy equals RAS_DEPTH.
REQ-017 ras_ckpt_tos_o  output  PTR_W  current tos, before this cycle's operation, travels with the branch.
REQ-018 ras_ckpt_cnt_o  output  PTR_W+1  current occupancy, before this cycle's operation.
REQ-019 ras_ckpt_data_o  output  64  entry[tos], before this cycle's operation.

Function
REQ-020 tos SHALL point at the most recently pushed entry; all pointer arithmetic SHALL wrap modulo RAS_DEPTH.
REQ-021 Push (01, valid) SHALL write entry[tos+1] = pushpc, set tos = tos+1, and set cnt = min(cnt+1, RAS_DEPTH); when full, the oldest entry is overwritten.
REQ-022 Pop (10, valid) SHALL present entry[tos] on ras_target_f0_o in the same cycle, then set tos = tos-1 and cnt = cnt-1.
REQ-023 Pop on empty (cnt=0) SHALL leave tos and cnt unchanged, still drive entry[tos], and hold ras_empty_o at 1.
REQ-024 Pop-then-push (11, valid) SHALL present the old entry[tos], write entry[tos] = pushpc, leave tos unchanged, and set cnt = max(cnt,1).
REQ-025 Control 00, or ras_valid_f0_i=0, SHALL leave all state unchanged.
REQ-026 State updates SHALL take effect at the next rising edge (1-cycle latency); ras_target_f0_o SHALL NOT bypass a same-cycle push.
REQ-027 Recovery SHALL, in one cycle, restore tos = recover_tos, cnt = recover_cnt, and entry[recover_tos] = recover_data.
REQ-028 In the same cycle, recovery SHALL then apply recover_ctl with recover_pc to the restored state under REQ-021..REQ-025 rules.
REQ-029 When recovery re-applies pop-then-push, recover_pc SHALL override recover_data at entry[recover_tos].
REQ-030 When ras_recover_i and ras_valid_f0_i are both asserted, recovery SHALL win and the f0 operation SHALL be dropped.
REQ-031 Checkpoint outputs SHALL reflect the pre-edge state every cycle, regardless of ras_valid_f0_i.
REQ-032 Occupancy SHALL saturate in the range 0..RAS_DEPTH; ras_full_o and ras_empty_o SHALL be mutually exclusive.

Reset
REQ-033 Asserting reset_n low SHALL immediately clear all entries to 0, tos to 0, and cnt to 0.
REQ-034 Under reset, ras_target_f0_o=0, ras_empty_o=1, ras_full_o=0, and all checkpoint outputs=0.
REQ-035 Reset asserted mid-operation SHALL discard any pending push, pop, or recovery.

Structure
REQ-036 RAS control encodings (RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH) and the default RAS_DEPTH SHALL live in the shared fetch package alongside the BR_* branch-type constants.
REQ-037 The block SHALL be a single module with no sub-module; the entry array is a flop array, no SRAM macro.

Verification
REQ-038 Push 0x1000, 0x2000, then pop twice -> targets 0x2000 then 0x1000; ras_empty_o=1 afterwards.
REQ-039 17 pushes of 0x100*k (k=1..17), then 16 pops -> targets 0x1100 down to 0x200; ras_full_o=1 after push 16; cnt stays 16.
REQ-040 Pop on empty after reset -> target 0, tos=0, cnt=0, ras_empty_o stays 1.
REQ-041 Push 0xA0 with ckpt (tos=1, cnt=1, data=0xA0) captured; then push 0xB0 and pop-then-push 0xC0; then recover with ckpt and ctl=pop -> tos=0, cnt=0, empty=1.
REQ-042 Recover (tos=3, cnt=3, data=0x40, ctl=push, pc=0x50) simultaneous with f0 push 0x99 -> tos=4, entry[4]=0x50, entry[3]=0x40, and 0x99 is never written.
REQ-043 Pop-then-push 0x77 on stack top 0x33 -> target 0x33 that cycle, next-cycle target 0x77, cnt unchanged.

Source files
------------

// File: rtl/fetch_ras_pkg.sv
// fetch_ras_pkg: shared fetch constants (branch types, RAS control encodings, RAS sizing).
package fetch_ras_pkg;

  localparam int RAS_DEPTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_COND = 3'd1,
    BR_JAL  = 3'd2,
    BR_JALR = 3'd3,
    BR_CALL = 3'd4,
    BR_RET  = 3'd5
  } br_type_e;

  typedef enum logic [1:0] {
    RAS_NONE    = 2'b00,
    RAS_PUSH    = 2'b01,
    RAS_POP     = 2'b10,
    RAS_POPPUSH = 2'b11
  } ras_ctl_e;

endpackage

// File: rtl/fetch_ras.sv
// fetch_ras: return address stack for the f0 fetch stage with single-cycle checkpoint recovery.
module fetch_ras
  import fetch_ras_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT,
  parameter int PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ras_valid_f0_i,
  input  logic [1:0]       ras_ctl_f0_i,
  input  logic [63:0]      ras_pushpc_f0_i,
  input  logic             ras_recover_i,
  input  logic [PTR_W-1:0] ras_recover_tos_i,
  input  logic [PTR_W:0]   ras_recover_cnt_i,
  input  logic [63:0]      ras_recover_data_i,
  input  logic [1:0]       ras_recover_ctl_i,
  input  logic [63:0]      ras_recover_pc_i,
  output logic [63:0]      ras_target_f0_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic [PTR_W-1:0] ras_ckpt_tos_o,
  output logic [PTR_W:0]   ras_ckpt_cnt_o,
  output logic [63:0]      ras_ckpt_data_o
);
  localparam logic [PTR_W:0]   FULL  = (PTR_W+1)'(RAS_DEPTH);
  localparam logic [PTR_W:0]   ONE_C = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_P = PTR_W'(1);
  logic [63:0]      entry [RAS_DEPTH];
  logic [PTR_W-1:0] tos_q, base_tos, tos_d, wr_idx;
  logic [PTR_W:0]   cnt_q, base_cnt, cnt_d;
  logic [1:0]       op;
  logic [63:0]      op_pc;
  logic             wr_en, nonzero;
  assign ras_target_f0_o = entry[tos_q];
  assign ras_empty_o     = cnt_q == '0;
  assign ras_full_o      = cnt_q == FULL;
  assign ras_ckpt_tos_o  = tos_q;
  assign ras_ckpt_cnt_o  = cnt_q;
  assign ras_ckpt_data_o = entry[tos_q];
  // Recovery restores the checkpoint first, then re-applies the branch's own control on top of it.
  always_comb begin
    base_tos = ras_recover_i ? ras_recover_tos_i : tos_q;
    base_cnt = ras_recover_i ? (ras_recover_cnt_i > FULL ? FULL : ras_recover_cnt_i) : cnt_q;
    op       = ras_recover_i ? ras_recover_ctl_i : ras_valid_f0_i ? ras_ctl_f0_i : RAS_NONE;
    op_pc    = ras_recover_i ? ras_recover_pc_i : ras_pushpc_f0_i;
    nonzero  = base_cnt != '0;
    tos_d    = op == RAS_PUSH ? base_tos + ONE_P :
               (op == RAS_POP && nonzero) ? base_tos - ONE_P : base_tos;
    cnt_d    = op == RAS_PUSH ? (base_cnt == FULL ? FULL : base_cnt + ONE_C) :
               (op == RAS_POP && nonzero) ? base_cnt - ONE_C :
               (op == RAS_POPPUSH && !nonzero) ? ONE_C : base_cnt;
    wr_en    = op == RAS_PUSH || op == RAS_POPPUSH;
    wr_idx   = op == RAS_PUSH ? base_tos + ONE_P : base_tos;
  end
  // The re-applied write is issued after the checkpoint restore so a pop-then-push pc wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tos_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entry[i] <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      if (ras_recover_i) entry[ras_recover_tos_i] <= ras_recover_data_i;
      if (wr_en) entry[wr_idx] <= op_pc;
    end
  end
endmodule
